// File: rtl/converter_sched.sv
// rtl/converter_sched.sv - two-requester round-robin scheduler that serialises 16-bit words into a byte stream
module converter_sched #(
    parameter int MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] data0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt1,
    output logic [7:0]  dataout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_src,
    output logic        busy,
    output logic [7:0]  word_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] hold;
    logic        last_gnt;
    logic        req_any;
    logic        winner;
    logic        capture;
    logic        word_done;

    // Tie goes to whoever was not granted last; a lone requester always wins.
    assign req_any = req0 | req1;
    assign winner  = (req0 & req1) ? ~last_gnt : req1;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    capture    = 1'b1;
                    state_next = FIRST;
                end
            end
            FIRST: begin
                if (out_ready) begin
                    state_next = SECOND;
                end
            end
            SECOND: begin
                if (out_ready) begin
                    word_done = 1'b1;
                    if (req_any) begin
                        capture    = 1'b1;
                        state_next = FIRST;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= 16'h0000;
            last_gnt <= 1'b1;
            word_cnt <= 8'h00;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            out_src  <= 1'b0;
        end else begin
            state <= state_next;
            gnt0  <= capture & ~winner;
            gnt1  <= capture & winner;
            if (capture) begin
                hold     <= winner ? data1 : data0;
                out_src  <= winner;
                last_gnt <= winner;
            end
            if (word_done) begin
                word_cnt <= word_cnt + 8'd1;
            end
        end
    end

    // Stream outputs decode only registered state so nothing flows through from the inputs.
    always_comb begin
        dataout = 8'h00;
        case (state)
            FIRST:   dataout = (MSB_FIRST != 0) ? hold[15:8] : hold[7:0];
            SECOND:  dataout = (MSB_FIRST != 0) ? hold[7:0]  : hold[15:8];
            default: dataout = 8'h00;
        endcase
    end

    assign out_valid = (state != IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_converter_sched.sv
// tb/tb_converter_sched.sv - directed self-checking bench for converter_sched
module tb_converter_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, out_ready;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1, out_valid, out_src, busy;
    logic [7:0]  dataout, word_cnt;

    logic        req_b, ready_b;
    logic [15:0] data_b;
    logic        gnt0_b, gnt1_b, valid_b, src_b, busy_b;
    logic [7:0]  dataout_b, word_cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    converter_sched #(.MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .dataout(dataout), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src), .busy(busy), .word_cnt(word_cnt)
    );

    converter_sched #(.MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst),
        .req0(req_b), .data0(data_b), .gnt0(gnt0_b),
        .req1(1'b0), .data1(16'h0000), .gnt1(gnt1_b),
        .dataout(dataout_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_src(src_b), .busy(busy_b), .word_cnt(word_cnt_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 16'h0; data1 = 16'h0;
        out_ready = 1'b0; req_b = 1'b0; data_b = 16'h0; ready_b = 1'b0;
        #1;

        // Reset held 4 cycles with a request present: no grant may appear
        req0 = 1'b1; data0 = 16'h3524; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_no_gnt", 16'({gnt0, gnt1}), 16'h0);
        end
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_dataout", 16'(dataout), 16'h00);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_wcnt", 16'(word_cnt), 16'h00);
        check("rst_src", 16'(out_src), 16'h0);

        // Basic word 3524
        rst = 1'b0;
        tick();
        check("w1_gnt0", 16'(gnt0), 16'h1);
        check("w1_first", 16'(dataout), 16'h35);
        check("w1_valid", 16'(out_valid), 16'h1);
        req0 = 1'b0;
        tick();
        check("w1_gnt_pulse", 16'(gnt0), 16'h0);
        check("w1_second", 16'(dataout), 16'h24);
        tick();
        check("w1_wcnt", 16'(word_cnt), 16'h01);
        check("w1_idle_valid", 16'(out_valid), 16'h0);
        check("w1_idle_data", 16'(dataout), 16'h00);

        // Tie from fresh reset: requester 0 first, then 1 back-to-back
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1'b1; data0 = 16'h5E81; req1 = 1'b1; data1 = 16'hD609;
        tick();
        check("rr_b0", 16'(dataout), 16'h5E);
        check("rr_s0", 16'(out_src), 16'h0);
        check("rr_g0", 16'({gnt0, gnt1}), 16'h2);
        req0 = 1'b0;
        tick();
        check("rr_b1", 16'(dataout), 16'h81);
        check("rr_s1", 16'(out_src), 16'h0);
        tick();
        check("rr_b2", 16'(dataout), 16'hD6);
        check("rr_s2", 16'(out_src), 16'h1);
        check("rr_g2", 16'({gnt0, gnt1}), 16'h1);
        req1 = 1'b0;
        tick();
        check("rr_b3", 16'(dataout), 16'h09);
        check("rr_s3", 16'(out_src), 16'h1);
        check("rr_g3", 16'({gnt0, gnt1}), 16'h0);
        tick();
        check("rr_wcnt", 16'(word_cnt), 16'h02);
        check("rr_idle", 16'(busy), 16'h0);

        // Backpressure in FIRST for 3 cycles
        req0 = 1'b1; data0 = 16'h5663; out_ready = 1'b0;
        tick();
        check("bp_first", 16'(dataout), 16'h56);
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data", 16'(dataout), 16'h56);
            check("bp_hold_valid", 16'(out_valid), 16'h1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_second", 16'(dataout), 16'h63);
        tick();
        check("bp_wcnt", 16'(word_cnt), 16'h03);

        // Reset during SECOND abandons the word
        req0 = 1'b1; data0 = 16'h7B0D;
        tick();
        check("mr_first", 16'(dataout), 16'h7B);
        req0 = 1'b0;
        tick();
        check("mr_second", 16'(dataout), 16'h0D);
        rst = 1'b1;
        tick();
        check("mr_valid", 16'(out_valid), 16'h0);
        check("mr_wcnt", 16'(word_cnt), 16'h00);
        check("mr_busy", 16'(busy), 16'h0);
        rst = 1'b0;

        // LSB-first instance
        req_b = 1'b1; data_b = 16'h998D; ready_b = 1'b1;
        tick();
        check("lsb_first", 16'(dataout_b), 16'h8D);
        req_b = 1'b0;
        tick();
        check("lsb_second", 16'(dataout_b), 16'h99);
        tick();
        check("lsb_wcnt", 16'(word_cnt_b), 16'h01);

        // 256 back-to-back words wrap word_cnt
        req0 = 1'b1; data0 = 16'hA000;
        tick();
        for (int i = 0; i < 256; i++) begin
            if (i == 7) check("wrap_mid_first", 16'(dataout), 16'hA0);
            tick();
            if (i == 255) req0 = 1'b0;
            tick();
            if (i == 254) check("wrap_255", 16'(word_cnt), 16'h00FF);
        end
        check("wrap_zero", 16'(word_cnt), 16'h00);
        check("wrap_idle", 16'(out_valid), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/converter_sched.md
CONVERTER_SCHED -- requirements
Module: converter_sched

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1, selecting byte order: 1 = bits[15:8] first, 0 = bits[7:0] first.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req0, input, 1 bit: requester 0 has a 16-bit word pending.
REQ-005 The block SHALL have port data0, input, 16 bits: requester 0 word, held stable while req0=1.
REQ-006 The block SHALL have port gnt0, output, 1 bit: one-cycle pulse, requester 0 word captured.
REQ-007 The block SHALL have ports req1, data1 and gnt1, identical in direction, width and meaning to req0, data0 and gnt0, for requester 1.
REQ-008 The block SHALL have port dataout, output, 8 bits: byte stream toward the downstream sink.
REQ-009 The block SHALL have port out_valid, output, 1 bit: dataout holds a valid byte.
REQ-010 The block SHALL have port out_ready, input, 1 bit: sink accepts the byte when out_valid=1 and out_ready=1.
REQ-011 The block SHALL have port out_src, output, 1 bit: index of the requester whose word is on dataout.
REQ-012 The block SHALL have port busy, output, 1 bit: FSM not in IDLE.
REQ-013 The block SHALL have port word_cnt, output, 8 bits: count of fully transferred words.

Function
REQ-014 The FSM SHALL have exactly 3 states: IDLE, FIRST and SECOND.
REQ-015 In IDLE, a rising edge with req0 or req1 high SHALL capture the winner's data into a 16-bit hold register, set out_src, pulse the winner's gnt high for the following cycle, and move to FIRST.
REQ-016 Arbitration SHALL be round-robin on a 1-bit last-grant pointer: if only one requester is high, it wins; if both are high, the one not granted last wins; the pointer updates on every capture.
REQ-017 In FIRST, out_valid SHALL be 1 and dataout SHALL be the first byte per MSB_FIRST; on out_ready=1 the FSM SHALL move to SECOND, otherwise it SHALL hold with dataout stable.
REQ-018 In SECOND, out_valid SHALL be 1 and dataout SHALL be the other byte; on out_ready=1, word_cnt SHALL increment, wrapping 8'hFF to 8'h00.
REQ-019 On out_ready=1 in SECOND with a request pending, the block SHALL capture the next word per REQ-015/016 and go directly to FIRST (back-to-back, 2 cycles/word); with no request pending, it SHALL go to IDLE.
REQ-020 Latency SHALL be: request sampled at edge N -> gnt and first byte valid in cycle N+1.
REQ-021 gnt0 and gnt1 SHALL never be high in the same cycle, and each pulse SHALL last exactly 1 cycle.
REQ-022 Requesters SHALL drop req on the edge after seeing gnt; the block SHALL NOT re-sample req in the gnt cycle, because the FSM is then in FIRST.
REQ-023 dataout, out_valid, out_src and busy SHALL be functions of registered state only, with no combinational path from req, data or out_ready.
REQ-024 In IDLE, out_valid SHALL be 0 and dataout SHALL be 8'h00.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL set state=IDLE, hold=16'h0000, pointer=1 (so requester 0 wins the first tie), word_cnt=8'h00, gnt0=gnt1=0, out_src=0 and busy=0, and out_valid=0 and dataout=8'h00 per REQ-024.
REQ-026 Reset mid-word SHALL abandon the word without incrementing word_cnt, and out_valid SHALL be 0 in the cycle after the reset edge.
REQ-027 While rst=1, requests SHALL be ignored and no gnt SHALL be issued.

Verification
REQ-028 The bench SHALL drive rst=1 for 4 cycles then 0, with req0=1, data0=16'h3524 and out_ready=1 -> gnt0 pulse, dataout 8'h35 then 8'h24, word_cnt=1.
REQ-029 The bench SHALL, from IDLE, raise req0 (16'h5E81) and req1 (16'hD609) in the same cycle -> word 0 is served first, then word 1 back-to-back: dataout 5E,81,D6,09 on consecutive cycles, out_src 0,0,1,1.
REQ-030 The bench SHALL hold out_ready=0 for 3 cycles during FIRST with word 16'h5663 -> dataout stays 8'h56 with out_valid=1, and 8'h63 follows after out_ready rises.
REQ-031 The bench SHALL assert rst during SECOND of word 16'h7B0D -> out_valid=0 next cycle and word_cnt unchanged/zeroed per REQ-025.
REQ-032 The bench SHALL set MSB_FIRST=0 with word 16'h998D -> dataout 8'h8D then 8'h99.
REQ-033 The bench SHALL transfer 256 words -> word_cnt wraps to 8'h00.
